// File: rtl/hilo_unit_pkg.sv
// rtl/hilo_unit_pkg.sv - shared types and constants for the HI/LO multiply/divide result unit
package hilo_unit_pkg;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 5;
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 16;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - pipeline-side request/response bundle of the HI/LO unit
interface hilo_unit_if;
    import hilo_unit_pkg::*;

    logic  md_start;
    logic  md_div;
    logic  div_zero;
    word_t lo_in;
    word_t hi_in;
    logic  mthi;
    logic  mtlo;
    word_t wdata;
    logic  mfhi;
    logic  mflo;
    word_t rdata;
    logic  busy;
    logic  stall;
    logic  dz_err;
    word_t hi;
    word_t lo;

    modport master (
        output md_start, md_div, div_zero, lo_in, hi_in,
        output mthi, mtlo, wdata, mfhi, mflo,
        input  rdata, busy, stall, dz_err, hi, lo
    );

    modport slave (
        input  md_start, md_div, div_zero, lo_in, hi_in,
        input  mthi, mtlo, wdata, mfhi, mflo,
        output rdata, busy, stall, dz_err, hi, lo
    );

endinterface

// File: rtl/hilo_lat_counter.sv
// rtl/hilo_lat_counter.sv - loadable 5-bit latency down-counter with zero flag
module hilo_lat_counter
    import hilo_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Saturates at zero so a stray decrement can never wrap to 31.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register file with fixed-latency multiply/divide commit
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    hilo_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t state, state_nxt;
    logic   accept, commit, cnt_dec, cnt_zero;
    logic   any_req, mv_en;
    word_t  hi_r, lo_r, pend_hi, pend_lo;
    logic   pend_dz, dz_r;

    hilo_lat_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (bus.md_div ? DIV_LOAD : MUL_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.md_start) begin
                    accept    = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_zero) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign any_req = bus.md_start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo;
    // Any move presented while busy raises stall, so moves only take effect in IDLE.
    assign mv_en   = (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r    <= '0;
            lo_r    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_dz <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            dz_r <= commit & pend_dz;
            if (accept) begin
                pend_hi <= bus.hi_in;
                pend_lo <= bus.lo_in;
                pend_dz <= bus.md_div & bus.div_zero;
            end
            if (commit) begin
                if (!pend_dz) begin
                    hi_r <= pend_hi;
                    lo_r <= pend_lo;
                end
            end else begin
                if (mv_en && bus.mthi) hi_r <= bus.wdata;
                if (mv_en && bus.mtlo) lo_r <= bus.wdata;
            end
        end
    end

    assign bus.busy   = (state == ST_BUSY);
    assign bus.stall  = (state == ST_BUSY) & any_req;
    assign bus.dz_err = dz_r;
    assign bus.hi     = hi_r;
    assign bus.lo     = lo_r;
    assign bus.rdata  = bus.mfhi ? hi_r : (bus.mflo ? lo_r : '0);

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - self-checking bench for hilo_unit
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;

    logic clk = 1'b0;
    logic rst;
    hilo_unit_if bus();

    hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference: an operation occupies the unit for LAT cycles, then lands in HI/LO.
    int          m_left;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pdz, m_dz;

    logic [98:0] got;
    assign got = {bus.busy, bus.stall, bus.dz_err, bus.rdata, bus.hi, bus.lo};

    function automatic logic [98:0] model_vec();
        logic        b, s;
        logic [31:0] rd;
        b  = (m_left > 0);
        s  = b & (bus.md_start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo);
        rd = bus.mfhi ? m_hi : (bus.mflo ? m_lo : 32'h0);
        return {b, s, m_dz, rd, m_hi, m_lo};
    endfunction

    task automatic model_reset();
        m_left = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pdz = 0; m_dz = 0;
    endtask

    task automatic model_edge();
        logic new_dz;
        new_dz = 1'b0;
        if (m_left == 0) begin
            if (bus.mthi) m_hi = bus.wdata;
            if (bus.mtlo) m_lo = bus.wdata;
            if (bus.md_start) begin
                m_phi  = bus.hi_in;
                m_plo  = bus.lo_in;
                m_pdz  = bus.md_div & bus.div_zero;
                m_left = bus.md_div ? DIV_LAT : MUL_LAT;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (!m_pdz) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
                new_dz = m_pdz;
            end
        end
        m_dz = new_dz;
    endtask

    task automatic clear_inputs();
        bus.md_start = 0; bus.md_div = 0; bus.div_zero = 0;
        bus.hi_in = 0; bus.lo_in = 0; bus.wdata = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.mfhi = 0; bus.mflo = 0;
    endtask

    task automatic step_begin();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic step_end();
        @(posedge clk);
        model_edge();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_total++;
        if (got !== 99'h0) $display("FAIL reset_state: got %h expected 0", got);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_mul();
        step_begin();
        bus.md_start = 1; bus.md_div = 0; bus.hi_in = 32'h1; bus.lo_in = 32'hFFFFFFFE;
        #1;
        n_total++;
        if (got !== model_vec()) $display("FAIL mul_start: got %h expected %h", got, model_vec());
        else n_pass++;
        step_end();
        for (int i = 0; i < MUL_LAT; i++) begin
            step_begin();
            bus.mflo = 1;
            #1;
            n_total++;
            if ({bus.busy, bus.stall} !== 2'b11 || got !== model_vec())
                $display("FAIL mul_busy_stall[%0d]: got %h expected %h", i, got, model_vec());
            else n_pass++;
            step_end();
        end
        step_begin();
        bus.mflo = 1;
        #1;
        n_total++;
        if ({bus.busy, bus.stall, bus.rdata, bus.hi, bus.lo} !== {2'b00, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE})
            $display("FAIL mul_result: got hi=%h lo=%h rdata=%h busy=%b expected hi=00000001 lo=fffffffe rdata=fffffffe busy=0",
                     bus.hi, bus.lo, bus.rdata, bus.busy);
        else n_pass++;
        step_end();
    endtask

    task automatic test_div();
        int  nbusy;
        bit  done;
        nbusy = 0;
        done  = 0;
        step_begin();
        bus.md_start = 1; bus.md_div = 1; bus.hi_in = 32'h3; bus.lo_in = 32'h21;
        step_end();
        for (int i = 0; i < 40 && !done; i++) begin
            step_begin();
            bus.mfhi = 1;
            #1;
            if (bus.busy) nbusy++;
            else begin
                done = 1;
                n_total++;
                if (bus.rdata !== 32'h3 || bus.lo !== 32'h21)
                    $display("FAIL div_result: got rdata=%h lo=%h expected rdata=00000003 lo=00000021", bus.rdata, bus.lo);
                else n_pass++;
            end
            n_total++;
            if (got !== model_vec()) $display("FAIL div_cycle[%0d]: got %h expected %h", i, got, model_vec());
            else n_pass++;
            step_end();
        end
        n_total++;
        if (!done || nbusy != DIV_LAT) $display("FAIL div_busy_len: got %0d expected %0d (done=%0d)", nbusy, DIV_LAT, done);
        else n_pass++;
    endtask

    task automatic test_div_zero();
        int npulse, at;
        npulse = 0;
        at     = -1;
        step_begin();
        bus.mthi = 1; bus.wdata = 32'hAAAA5555;
        step_end();
        step_begin();
        bus.md_start = 1; bus.md_div = 1; bus.div_zero = 1;
        bus.hi_in = $urandom; bus.lo_in = $urandom;
        step_end();
        for (int i = 0; i < 20; i++) begin
            step_begin();
            #1;
            if (bus.dz_err) begin
                npulse++;
                if (at < 0) at = i;
            end
            n_total++;
            if (got !== model_vec()) $display("FAIL dz_cycle[%0d]: got %h expected %h", i, got, model_vec());
            else n_pass++;
            step_end();
        end
        n_total++;
        if (npulse != 1 || at != DIV_LAT || bus.hi !== 32'hAAAA5555)
            $display("FAIL dz_pulse: got pulses=%0d at=%0d hi=%h expected pulses=1 at=%0d hi=aaaa5555", npulse, at, bus.hi, DIV_LAT);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ah, al, bh, bl;
        int          nstall;
        bit          acc, done;
        ah = $urandom; al = $urandom; bh = $urandom; bl = $urandom;
        nstall = 0; acc = 0; done = 0;
        step_begin();
        bus.md_start = 1; bus.md_div = 0; bus.hi_in = ah; bus.lo_in = al;
        step_end();
        for (int i = 0; i < 40 && !acc; i++) begin
            step_begin();
            bus.md_start = 1; bus.md_div = 1; bus.hi_in = bh; bus.lo_in = bl;
            #1;
            if (bus.busy) begin
                if (bus.stall) nstall++;
            end else begin
                acc = 1;
                n_total++;
                if (bus.hi !== ah || bus.lo !== al)
                    $display("FAIL b2b_first: got hi=%h lo=%h expected hi=%h lo=%h", bus.hi, bus.lo, ah, al);
                else n_pass++;
            end
            n_total++;
            if (got !== model_vec()) $display("FAIL b2b_cycle[%0d]: got %h expected %h", i, got, model_vec());
            else n_pass++;
            step_end();
        end
        n_total++;
        if (!acc || nstall != MUL_LAT) $display("FAIL b2b_stall: got %0d stalled cycles expected %0d", nstall, MUL_LAT);
        else n_pass++;
        for (int i = 0; i < 40 && !done; i++) begin
            step_begin();
            #1;
            if (!bus.busy) done = 1;
            step_end();
        end
        n_total++;
        if (!done || bus.hi !== bh || bus.lo !== bl)
            $display("FAIL b2b_second: got hi=%h lo=%h expected hi=%h lo=%h", bus.hi, bus.lo, bh, bl);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        step_begin();
        bus.mthi = 1; bus.mtlo = 1; bus.wdata = $urandom | 32'h1;
        step_end();
        step_begin();
        bus.md_start = 1; bus.md_div = 1; bus.hi_in = $urandom | 32'h1; bus.lo_in = $urandom | 32'h1;
        step_end();
        repeat (2) begin
            step_begin();
            step_end();
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus.busy, bus.dz_err, bus.hi, bus.lo} !== 66'h0)
            $display("FAIL rst_async: got busy=%b hi=%h lo=%h expected all 0", bus.busy, bus.hi, bus.lo);
        else n_pass++;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        for (int i = 0; i < DIV_LAT + 4; i++) begin
            step_begin();
            #1;
            n_total++;
            if (got !== model_vec()) $display("FAIL rst_no_commit[%0d]: got %h expected %h", i, got, model_vec());
            else n_pass++;
            step_end();
        end
        step_begin();
        bus.mthi = 1; bus.wdata = 32'h00005A5A;
        step_end();
        step_begin();
        #1;
        n_total++;
        if (bus.hi !== 32'h00005A5A || bus.lo !== 32'h0)
            $display("FAIL rst_after: got hi=%h lo=%h expected hi=00005a5a lo=00000000", bus.hi, bus.lo);
        else n_pass++;
        step_end();
    endtask

    task automatic test_moves();
        logic [31:0] x, y, w;
        step_begin();
        bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'h12345678;
        step_end();
        step_begin();
        bus.mfhi = 1; bus.mflo = 1;
        #1;
        n_total++;
        if (bus.rdata !== 32'h12345678 || bus.hi !== 32'h12345678 || bus.lo !== 32'h12345678)
            $display("FAIL mv_both: got rdata=%h hi=%h lo=%h expected 12345678", bus.rdata, bus.hi, bus.lo);
        else n_pass++;
        bus.mflo = 0;
        bus.mtlo = 1; bus.wdata = 32'hCAFEF00D;
        step_end();
        step_begin();
        bus.mfhi = 1; bus.mflo = 1;
        bus.mthi = 1; bus.wdata = 32'h0BADBEEF;
        #1;
        n_total++;
        if (bus.rdata !== 32'h12345678 || bus.lo !== 32'hCAFEF00D)
            $display("FAIL mf_hi_wins_old: got rdata=%h lo=%h expected rdata=12345678 lo=cafef00d", bus.rdata, bus.lo);
        else n_pass++;
        step_end();
        x = $urandom; y = $urandom; w = $urandom;
        step_begin();
        bus.md_start = 1; bus.hi_in = x; bus.lo_in = y; bus.mthi = 1; bus.wdata = w;
        step_end();
        step_begin();
        #1;
        n_total++;
        if (bus.hi !== w || bus.lo !== 32'hCAFEF00D)
            $display("FAIL mv_with_start: got hi=%h lo=%h expected hi=%h lo=cafef00d", bus.hi, bus.lo, w);
        else n_pass++;
        step_end();
        repeat (MUL_LAT) begin
            step_begin();
            step_end();
        end
        step_begin();
        #1;
        n_total++;
        if (bus.hi !== x || bus.lo !== y)
            $display("FAIL commit_overwrites: got hi=%h lo=%h expected hi=%h lo=%h", bus.hi, bus.lo, x, y);
        else n_pass++;
        step_end();
    endtask

    task automatic test_random();
        int nbad;
        nbad = 0;
        for (int i = 0; i < 800; i++) begin
            step_begin();
            bus.md_start = ($urandom_range(0, 3) == 0);
            bus.md_div   = $urandom_range(0, 1);
            bus.div_zero = ($urandom_range(0, 3) == 0);
            bus.hi_in    = $urandom;
            bus.lo_in    = $urandom;
            bus.wdata    = $urandom;
            bus.mthi     = ($urandom_range(0, 5) == 0);
            bus.mtlo     = ($urandom_range(0, 5) == 0);
            bus.mfhi     = ($urandom_range(0, 2) == 0);
            bus.mflo     = ($urandom_range(0, 2) == 0);
            #1;
            n_total++;
            if (got !== model_vec()) begin
                nbad++;
                if (nbad <= 10) $display("FAIL random[%0d]: got %h expected %h", i, got, model_vec());
            end else n_pass++;
            step_end();
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_moves();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
